// File: rtl/serial_adder_acc_if.sv
// Bundle of the request/response signals of the bit-serial adder/accumulator.
// The driver (testbench or host logic) uses the master modport; the core uses slave.
interface serial_adder_acc_if #(
   parameter int WIDTH = 8
);
   logic             ena;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic [WIDTH-1:0] acc;

   modport master (
      output ena, start, op, a, b,
      input  busy, done, sum, carry_out, overflow, acc
   );

   modport slave (
      input  ena, start, op, a, b,
      output busy, done, sum, carry_out, overflow, acc
   );
endinterface

// File: rtl/serial_adder_acc.sv
// Bit-serial adder/subtractor with accumulator. One full-adder cell with a
// registered carry processes the operands LSB-first, one bit per clock.
// Ops: ADD a+b, SUB a-b (a + ~b + 1), ACC acc+a, CLR acc<=0.
module serial_adder_acc #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_adder_acc_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] ra_reg;
   logic [WIDTH-1:0] rb_reg;
   logic [WIDTH-1:0] res_reg;
   logic             c_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_out_reg;
   logic             overflow_reg;
   logic [WIDTH-1:0] acc_reg;

   // Full-adder cell on the current LSBs; res_next is the result register
   // after this bit has been shifted in at the MSB end.
   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] res_next;

   // Combinational full-adder slice feeding the serial datapath.
   always_comb begin
      s_bit    = ra_reg[0] ^ rb_reg[0] ^ c_reg;
      c_next   = (ra_reg[0] & rb_reg[0]) | (ra_reg[0] & c_reg) | (rb_reg[0] & c_reg);
      res_next = {s_bit, res_reg[WIDTH-1:1]};
   end

   // Control FSM and serial datapath; every register freezes while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         op_reg        <= OP_ADD;
         ra_reg        <= '0;
         rb_reg        <= '0;
         res_reg       <= '0;
         c_reg         <= 1'b0;
         cnt_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         sum_reg       <= '0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         acc_reg       <= '0;
      end else if (bus.ena) begin
         case (state_reg)
            IDLE, DONE: begin
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
               if (bus.start) begin
                  // Capture operands once; later input changes do not matter.
                  op_reg  <= bus.op;
                  ra_reg  <= bus.a;
                  res_reg <= '0;
                  cnt_reg <= '0;
                  c_reg   <= (bus.op == OP_SUB);
                  case (bus.op)
                     OP_ADD:  rb_reg <= bus.b;
                     OP_SUB:  rb_reg <= ~bus.b;
                     OP_ACC:  rb_reg <= acc_reg;
                     default: rb_reg <= '0;
                  endcase
                  if (bus.op == OP_CLR) begin
                     // Clear needs no serial pass: finish on the next cycle.
                     acc_reg   <= '0;
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end
               end else begin
                  state_reg <= IDLE;
               end
            end

            RUN: begin
               ra_reg  <= {1'b0, ra_reg[WIDTH-1:1]};
               rb_reg  <= {1'b0, rb_reg[WIDTH-1:1]};
               res_reg <= res_next;
               c_reg   <= c_next;
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == LAST_BIT) begin
                  // c_reg is the carry into the MSB cell, c_next the carry out.
                  sum_reg       <= res_next;
                  carry_out_reg <= c_next;
                  overflow_reg  <= c_reg ^ c_next;
                  if (op_reg == OP_ACC) begin
                     acc_reg <= res_next;
                  end
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.sum       = sum_reg;
   assign bus.carry_out = carry_out_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.acc       = acc_reg;
endmodule

// File: doc/serial_adder_acc.md
# serial_adder_acc

Parametrised bit-serial adder/subtractor with an internal accumulator, successor to the single-bit half adder. Processes two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell with a registered carry. Adds subtract, accumulate and clear modes with a start/busy/done handshake. Sits behind the tile's dedicated inputs as the arithmetic core of the demo project.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes all state
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  00 ADD (a+b), 01 SUB (a−b), 10 ACC (acc+a), 11 CLR (acc←0)
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start; ignored for ACC/CLR
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  last result, held until next completion
- carry_out  out  1  final carry; for SUB, 1 = no borrow
- overflow  out  1  signed overflow of last ADD/SUB/ACC
- acc  out  WIDTH  accumulator contents

## Operation
- Asynchronous reset, active-low: state IDLE; busy, done, sum, carry_out, overflow, acc, bit counter and shift registers all 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 + ena=1: latch op; ra←a; rb←b (ADD), ~b (SUB), acc (ACC); c←1 for SUB else 0; cnt←0. CLR → DONE directly; others → RUN.
- Start with no start in DONE → IDLE after one cycle.
- RUN, each ena=1 edge: s = ra[0]^rb[0]^c; c ← majority(ra[0], rb[0], c); ra, rb shift right; result shift register shifts right with s entering at MSB; cnt++.
- On the edge where cnt = WIDTH−1: c_msb_in = carry into MSB cell (c before update); commit sum←result, carry_out←new c, overflow←c_msb_in ^ new c; for ACC also acc←result; → DONE.
- CLR: acc←0, sum/carry_out/overflow unchanged.
- done=1 only in DONE. busy=1 only in RUN.
- start while in RUN ignored, no queueing.
- Width rules: all arithmetic modulo 2^WIDTH. Counter is $clog2(WIDTH) bits. Operands captured once and unaffected by input changes during RUN.

## Timing
- ADD/SUB/ACC latency: start sampled at edge E0 → busy from E0 through E0+WIDTH; done high for the single cycle after edge E0+WIDTH; results valid at the same edge done rises.
- CLR latency: done high the cycle after E0; acc=0 at the same edge.
- Back-to-back: start during the done cycle is accepted. Throughput is one op per WIDTH+1 cycles (ADD/SUB/ACC).
- ena=0: every register holds, including done (pulse stretches) and cnt. Resumes exactly where stalled.
- Reset mid-RUN: immediate abort. Outputs return to reset values; no partial result is committed.
- start and ena=0 in the same cycle: start ignored.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 → busy for 8 cycles; done at E0+9th cycle; sum=0x00, carry_out=1, overflow=0.
- ADD a=0x7F b=0x01 → sum=0x80, carry_out=0, overflow=1. SUB a=0x05 b=0x07 → sum=0xFE, carry_out=0, overflow=0. SUB a=0x80 b=0x01 → sum=0x7F, overflow=1.
- CLR, then ACC a=0x10 three times back-to-back (start in each done cycle) → acc=0x10, 0x20, 0x30; sum tracks acc. Then CLR → acc=0x00, done one cycle after start.
- ADD 0x12+0x34 with start pulsed again mid-RUN and a/b changed after capture → single done; sum=0x46.
- ADD 0x0F+0x01 with ena low for 3 cycles mid-RUN → done delayed by exactly 3 cycles; sum=0x10. Hold ena low during done → done stays high until ena returns.
- rst_n low at cycle 4 of a RUN after a prior acc=0x30 → all outputs 0 immediately (asynchronous). No done. Next ADD 0x01+0x01 → 0x02.
